// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronised, deglitched clock, 11-bit frame decode with
// parity/stop/timeout checking, and a small FIFO whose head is presented as data/valid.
module ps2_rx_fifo #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 4800,
  parameter int DEPTH      = 4
) (
  input  logic                     clk_bus,
  input  logic                     nreset,
  input  logic                     PS2_CLK,
  input  logic                     PS2_DAT,
  input  logic                     ready,
  output logic [7:0]               data,
  output logic                     valid,
  output logic                     parity_err,
  output logic                     frame_err,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_CHECK
  } state_t;

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_clk_prev, r_clk_filt;
  logic [FW-1:0] r_filt_cnt;
  logic [FW-1:0] w_run;
  logic          w_fe;

  // w_run is the length of the current run of equal synchronised samples, saturating.
  always_comb begin
    if (r_clk_s2 != r_clk_prev)
      w_run = FW'(1);
    else if (r_filt_cnt == FW'(FILTER_LEN))
      w_run = r_filt_cnt;
    else
      w_run = r_filt_cnt + FW'(1);
  end

  assign w_fe = (w_run == FW'(FILTER_LEN)) && !r_clk_s2 && r_clk_filt;

  always_ff @(posedge clk_bus or negedge nreset) begin
    if (!nreset) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_clk_filt <= 1'b1;
      r_filt_cnt <= '0;
    end else begin
      r_clk_s1   <= PS2_CLK;
      r_clk_s2   <= r_clk_s1;
      r_dat_s1   <= PS2_DAT;
      r_dat_s2   <= r_dat_s1;
      r_clk_prev <= r_clk_s2;
      r_filt_cnt <= w_run;
      if (w_run == FW'(FILTER_LEN))
        r_clk_filt <= r_clk_s2;
    end
  end

  state_t      r_state, w_state_next;
  logic [7:0]  r_shift;
  logic [2:0]  r_bitcnt;
  logic        r_perr;
  logic        r_stop_bit;
  logic [15:0] r_to_cnt;
  logic        w_timeout;
  logic        w_push, w_perr_pulse, w_ferr_pulse;

  // A falling edge in the same cycle always beats the timeout.
  assign w_timeout = (r_state != S_IDLE) && !w_fe && (r_to_cnt == 16'(TIMEOUT));

  always_ff @(posedge clk_bus or negedge nreset) begin
    if (!nreset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    w_perr_pulse = 1'b0;
    w_ferr_pulse = 1'b0;
    if (w_timeout) begin
      w_state_next = S_IDLE;
      w_ferr_pulse = 1'b1;
    end else begin
      case (r_state)
        S_IDLE:   if (w_fe && !r_dat_s2) w_state_next = S_DATA;
        S_DATA:   if (w_fe && r_bitcnt == 3'd7) w_state_next = S_PARITY;
        S_PARITY: if (w_fe) w_state_next = S_STOP;
        S_STOP:   if (w_fe) w_state_next = S_CHECK;
        S_CHECK: begin
          w_state_next = S_IDLE;
          if (!r_stop_bit)
            w_ferr_pulse = 1'b1;
          else if (r_perr)
            w_perr_pulse = 1'b1;
          else
            w_push = 1'b1;
        end
        default:  w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_bus or negedge nreset) begin
    if (!nreset) begin
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_perr     <= 1'b0;
      r_stop_bit <= 1'b0;
      r_to_cnt   <= '0;
    end else begin
      if (r_state == S_IDLE || w_fe)
        r_to_cnt <= '0;
      else if (r_to_cnt != 16'hFFFF)
        r_to_cnt <= r_to_cnt + 16'd1;
      if (w_fe) begin
        case (r_state)
          S_IDLE:   r_bitcnt <= '0;
          S_DATA: begin
            r_shift  <= {r_dat_s2, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
          end
          S_PARITY: r_perr <= ~(^r_shift ^ r_dat_s2);
          S_STOP:   r_stop_bit <= r_dat_s2;
          default:  r_stop_bit <= r_stop_bit;
        endcase
      end
    end
  end

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_parity_err, r_frame_err, r_overflow;
  logic          w_pop, w_full, w_push_ok;
  logic [LW-1:0] w_level_next;
  logic [AW-1:0] w_rd_ptr_next;
  logic [7:0]    w_head_next;

  assign w_pop         = r_valid & ready;
  assign w_full        = (r_level == LW'(DEPTH));
  assign w_push_ok     = w_push & (!w_full | w_pop);
  assign w_rd_ptr_next = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
  // If the next read slot is the one being written, the FIFO was empty after the pop.
  assign w_head_next   = (w_push_ok && r_wr_ptr == w_rd_ptr_next) ? r_shift : r_mem[w_rd_ptr_next];

  always_comb begin
    w_level_next = r_level;
    if (w_push_ok && !w_pop)
      w_level_next = r_level + LW'(1);
    else if (!w_push_ok && w_pop)
      w_level_next = r_level - LW'(1);
  end

  always_ff @(posedge clk_bus) begin
    if (w_push_ok)
      r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge clk_bus or negedge nreset) begin
    if (!nreset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_push_ok)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr     <= w_rd_ptr_next;
      r_level      <= w_level_next;
      r_valid      <= (w_level_next != '0);
      if (w_level_next != '0)
        r_data <= w_head_next;
      r_parity_err <= w_perr_pulse;
      r_frame_err  <= w_ferr_pulse;
      r_overflow   <= w_push & ~w_push_ok;
    end
  end

  assign data       = r_data;
  assign valid      = r_valid;
  assign level      = r_level;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: glitch rejection, good/bad frames, timeout, overflow and
// mid-frame reset, with a shortened PS/2 bit period and timeout to keep the run small.
module tb_ps2_rx_fifo;

  localparam int FLEN = 8;
  localparam int TMO  = 200;
  localparam int DEP  = 4;
  localparam int H    = 40;

  logic       clk_bus = 1'b0;
  logic       nreset;
  logic       PS2_CLK, PS2_DAT, ready;
  logic [7:0] data;
  logic       valid, parity_err, frame_err, overflow;
  logic [2:0] level;

  int n_checks = 0;
  int n_errors = 0;

  ps2_rx_fifo #(.FILTER_LEN(FLEN), .TIMEOUT(TMO), .DEPTH(DEP)) dut (
    .clk_bus    (clk_bus),
    .nreset     (nreset),
    .PS2_CLK    (PS2_CLK),
    .PS2_DAT    (PS2_DAT),
    .ready      (ready),
    .data       (data),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .level      (level)
  );

  always #5 clk_bus = ~clk_bus;

  // Event counters and captured bytes (valid & ready), sampled on the inactive edge.
  int         mon_valid = 0, mon_perr = 0, mon_ferr = 0, mon_ovf = 0;
  logic [7:0] cap_q[$];

  always @(negedge clk_bus) begin
    if (valid) mon_valid <= mon_valid + 1;
    if (valid && ready) cap_q.push_back(data);
    if (parity_err) mon_perr <= mon_perr + 1;
    if (frame_err) mon_ferr <= mon_ferr + 1;
    if (overflow) mon_ovf <= mon_ovf + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_bus);
  endtask

  task automatic drive_clk(input logic v);
    @(posedge clk_bus);
    #1 PS2_CLK = v;
  endtask

  task automatic send_bit(input logic b);
    @(posedge clk_bus);
    #1 PS2_DAT = b;
    wait_cyc(H);
    drive_clk(1'b0);
    wait_cyc(H);
    drive_clk(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
    @(posedge clk_bus);
    #1 PS2_DAT = 1'b1;
    wait_cyc(2 * H);
  endtask

  int rd_idx = 0;

  task automatic rx_check(input string tag, input logic [7:0] exp_b, input int v0);
    chk({tag, " valid_cycles"}, mon_valid - v0, 1);
    chk({tag, " count"}, cap_q.size() - rd_idx, 1);
    if (cap_q.size() > rd_idx) begin
      chk({tag, " data"}, 32'(cap_q[rd_idx]), 32'(exp_b));
      rd_idx++;
    end
  endtask

  int         v0, p0, e0, o0;
  int         first_k, nhigh;
  logic [4:0] vbits;
  logic [7:0] good_bytes [3];

  initial begin
    good_bytes = '{8'h1C, 8'hF0, 8'hE0};
    PS2_CLK = 1'b1;
    PS2_DAT = 1'b1;
    ready   = 1'b1;
    nreset  = 1'b0;
    wait_cyc(5);
    chk("reset data", 32'(data), 32'h0);
    chk("reset valid", 32'(valid), 32'h0);
    chk("reset parity_err", 32'(parity_err), 32'h0);
    chk("reset frame_err", 32'(frame_err), 32'h0);
    chk("reset overflow", 32'(overflow), 32'h0);
    chk("reset level", 32'(level), 32'h0);
    @(posedge clk_bus);
    #1 nreset = 1'b1;
    wait_cyc(20);

    // 3-cycle clock glitch, first with idle data, then with data low so a leak would start a frame
    for (int g = 0; g < 2; g++) begin
      v0 = mon_valid; e0 = mon_ferr; p0 = mon_perr;
      @(posedge clk_bus);
      #1 PS2_DAT = (g == 0);
      drive_clk(1'b0);
      repeat (2) @(posedge clk_bus);
      drive_clk(1'b1);
      @(posedge clk_bus);
      #1 PS2_DAT = 1'b1;
      wait_cyc(TMO + 100);
      chk("glitch valid", mon_valid - v0, 0);
      chk("glitch frame_err", mon_ferr - e0, 0);
      chk("glitch parity_err", mon_perr - p0, 0);
      chk("glitch level", 32'(level), 32'h0);
    end

    e0 = mon_ferr; p0 = mon_perr;
    for (int i = 0; i < 3; i++) begin
      v0 = mon_valid;
      send_frame(good_bytes[i], odd_par(good_bytes[i]), 1'b1);
      rx_check("good byte", good_bytes[i], v0);
    end
    chk("good no frame_err", mon_ferr - e0, 0);
    chk("good no parity_err", mon_perr - p0, 0);

    // 0x1C with parity 1 is a parity error
    v0 = mon_valid; p0 = mon_perr; e0 = mon_ferr;
    send_frame(8'h1C, 1'b1, 1'b1);
    chk("badpar pulse", mon_perr - p0, 1);
    chk("badpar no frame_err", mon_ferr - e0, 0);
    chk("badpar no valid", mon_valid - v0, 0);
    chk("badpar level", 32'(level), 32'h0);
    v0 = mon_valid;
    send_frame(8'h5A, 1'b1, 1'b1);
    rx_check("after badpar 5A", 8'h5A, v0);

    // Stop bit 0 reports frame_err even though parity is also wrong
    v0 = mon_valid; p0 = mon_perr; e0 = mon_ferr;
    send_frame(8'h1C, 1'b1, 1'b0);
    chk("badstop frame_err", mon_ferr - e0, 1);
    chk("badstop no parity_err", mon_perr - p0, 0);
    chk("badstop no valid", mon_valid - v0, 0);

    // Timeout: start + 4 data bits. Filter/sync put fe on the 10th edge after the drive;
    // the counter reaches TMO, the FSM acts one edge later and the pulse is registered,
    // so frame_err is seen on negedge TMO+12 counted from the drive.
    v0 = mon_valid; p0 = mon_perr; e0 = mon_ferr;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    @(posedge clk_bus);
    #1 PS2_DAT = 1'b0;
    wait_cyc(H);
    drive_clk(1'b0);
    first_k = 0; nhigh = 0;
    for (int k = 1; k <= TMO + 40; k++) begin
      @(negedge clk_bus);
      if (k == H) PS2_CLK = 1'b1;
      if (frame_err) begin
        if (first_k == 0) first_k = k;
        nhigh++;
      end
    end
    PS2_DAT = 1'b1;
    chk("timeout latency", first_k, TMO + 12);
    chk("timeout width", nhigh, 1);
    chk("timeout no valid", mon_valid - v0, 0);
    chk("timeout no parity_err", mon_perr - p0, 0);
    wait_cyc(20);
    v0 = mon_valid;
    send_frame(8'h12, 1'b1, 1'b1);
    rx_check("after timeout 12", 8'h12, v0);

    // Overflow: fill with ready low, fifth byte dropped
    @(posedge clk_bus);
    #1 ready = 1'b0;
    o0 = mon_ovf;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), odd_par(8'(i)), 1'b1);
    chk("ovf level full", 32'(level), 32'd4);
    chk("ovf none yet", mon_ovf - o0, 0);
    send_frame(8'h05, 1'b1, 1'b1);
    chk("ovf pulse", mon_ovf - o0, 1);
    chk("ovf level still full", 32'(level), 32'd4);
    chk("ovf head unchanged", 32'(data), 32'h01);
    @(posedge clk_bus);
    #1 ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_bus);
      vbits[k] = valid;
    end
    chk("ovf drain valid pattern", 32'(vbits), 32'b01111);
    chk("ovf drained level", 32'(level), 32'h0);
    wait_cyc(5);
    chk("ovf drained count", cap_q.size() - rd_idx, 4);
    for (int i = 1; i <= 4; i++) begin
      if (cap_q.size() > rd_idx) begin
        chk("ovf drained data", 32'(cap_q[rd_idx]), i);
        rd_idx++;
      end
    end

    // Reset in the middle of 0x33 with two bytes held
    @(posedge clk_bus);
    #1 ready = 1'b0;
    send_frame(8'h44, 1'b1, 1'b1);
    send_frame(8'h55, 1'b1, 1'b1);
    chk("rst pre level", 32'(level), 32'd2);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    @(posedge clk_bus);
    #1 nreset = 1'b0;
    #1;
    chk("rst async data", 32'(data), 32'h0);
    chk("rst async valid", 32'(valid), 32'h0);
    chk("rst async level", 32'(level), 32'h0);
    wait_cyc(5);
    @(posedge clk_bus);
    #1 nreset = 1'b1;
    ready = 1'b1;
    wait_cyc(20);
    chk("rst post valid", 32'(valid), 32'h0);
    chk("rst post nothing captured", cap_q.size() - rd_idx, 0);
    v0 = mon_valid;
    send_frame(8'h21, 1'b1, 1'b1);
    rx_check("after reset 21", 8'h21, v0);

    chk("total overflow pulses", mon_ovf, 1);
    chk("total frame_err pulses", mon_ferr, 2);
    chk("total parity_err pulses", mon_perr, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
